// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// frame geometry and the image-capacity helper.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // Largest legal word count for a memory with addrW word-address bits.
  function automatic logic [16:0] maxWords(input int addrW);
    return 17'(1) << addrW;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; wordValid flags the byte
// that completes a word, with the finished word presented alongside it.
import loader_pkg::*;

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byteValid,
  input  logic [7:0]  byteIn,
  output logic [31:0] word,
  output logic        wordValid
);

  logic [1:0]  idx;
  logic [23:0] partial;

  assign wordValid = byteValid && (idx == 2'(BYTES_PER_WORD - 1));
  assign word      = {byteIn, partial};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (byteValid) begin
      idx <= idx + 2'd1;
    end
  end

  // Earlier bytes slide toward the LSB so the first byte ends up in [7:0].
  always_ff @(posedge clk) begin
    if (byteValid) begin
      partial <= {byteIn, partial[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte frame, writes words
// into instruction RAM and holds the core in reset until the image verifies.
import loader_pkg::*;

module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] MAX_WORDS = maxWords(ADDR_W);

  state_t              state;
  logic [7:0]          lenLo;
  logic [15:0]         len;
  logic [15:0]         hdrLen;
  logic [16:0]         wordCnt;
  logic [ADDR_W-1:0]   addrCnt;
  logic [7:0]          chk;
  logic                xfer;
  logic                sessionStart;
  logic                packValid;
  logic                wordValid;
  logic [31:0]         word;

  assign in_ready     = state inside {HDR_LO, HDR_HI, DATA, CHECK};
  assign busy         = in_ready;
  assign xfer         = in_valid && in_ready;
  assign sessionStart = start && (state inside {IDLE, DONE, ERR});
  assign packValid    = xfer && (state == DATA);
  assign hdrLen       = {in_data, lenLo};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (sessionStart),
    .byteValid (packValid),
    .byteIn    (in_data),
    .word      (word),
    .wordValid (wordValid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      wordCnt   <= '0;
      addrCnt   <= '0;
      chk       <= '0;
    end else begin
      mem_we <= 1'b0;
      if (sessionStart) begin
        state   <= HDR_LO;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
        err     <= 1'b0;
        wordCnt <= '0;
        addrCnt <= '0;
        chk     <= '0;
      end else if (xfer) begin
        case (state)
          HDR_LO: begin
            lenLo <= in_data;
            state <= HDR_HI;
          end
          HDR_HI: begin
            len <= hdrLen;
            if (hdrLen == 16'd0 || {1'b0, hdrLen} > MAX_WORDS) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
          DATA: begin
            chk <= chk ^ in_data;
            if (wordValid) begin
              mem_we    <= 1'b1;
              mem_addr  <= addrCnt;
              mem_wdata <= word;
              addrCnt   <= addrCnt + 1'b1;
              wordCnt   <= wordCnt + 17'd1;
              if (wordCnt + 17'd1 == {1'b0, len}) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            if (in_data == chk) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed images, bad checksum, bad headers,
// stalled stream, mid-session reset and a full-capacity image.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  // Write monitor: logs every mem_we cycle and counts back-to-back pulses.
  logic [ADDR_W-1:0] wrAddr [1024];
  logic [31:0]       wrData [1024];
  int                nWr = 0;
  int                weDouble = 0;
  logic              weLast = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (nWr < 1024) begin
        wrAddr[nWr] = mem_addr;
        wrData[nWr] = mem_wdata;
      end
      nWr++;
    end
    if (mem_we && weLast) weDouble++;
    weLast = mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wordOf(input int i);
    return {8'(i * 7 + 1), 8'(i ^ 90), 8'(i + 17), 8'(255 - i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 1);
      repeat (g) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Sends a full frame of wordOf(0..n-1); chkFlip corrupts the checksum and
  // start is held high across the first byte of word startWord.
  task automatic sendImage(input int n, input bit gaps, input logic [7:0] chkFlip, input int startWord);
    logic [7:0]  x;
    logic [31:0] w;
    logic [15:0] n16;
    n16 = 16'(n);
    x   = 8'h00;
    sendByte(n16[7:0], gaps);
    sendByte(n16[15:8], gaps);
    for (int i = 0; i < n; i++) begin
      w = wordOf(i);
      x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      if (i == startWord) start = 1'b1;
      sendByte(w[7:0], gaps);
      start = 1'b0;
      sendByte(w[15:8], gaps);
      sendByte(w[23:16], gaps);
      sendByte(w[31:24], gaps);
    end
    sendByte(x ^ chkFlip, gaps);
  endtask

  int base;
  int base2;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);

    // Two-word image; checksum of 05 00 08 20 04 00 09 8C is 0xAC
    base = nWr;
    pulseStart();
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_in_ready", {31'b0, in_ready}, 32'd1);
    sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h05, 0); sendByte(8'h00, 0); sendByte(8'h08, 0); sendByte(8'h20, 0);
    check("t1_we0", {31'b0, mem_we}, 32'd1);
    check("t1_addr0", {24'b0, mem_addr}, 32'd0);
    check("t1_data0", mem_wdata, 32'h20080005);
    sendByte(8'h04, 0);
    check("t1_we_drop", {31'b0, mem_we}, 32'd0);
    check("t1_addr_hold", {24'b0, mem_addr}, 32'd0);
    sendByte(8'h00, 0); sendByte(8'h09, 0); sendByte(8'h8C, 0);
    check("t1_we1", {31'b0, mem_we}, 32'd1);
    check("t1_addr1", {24'b0, mem_addr}, 32'd1);
    check("t1_data1", mem_wdata, 32'h8C090004);
    check("t1_pre_done", {31'b0, done}, 32'd0);
    check("t1_pre_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    sendByte(8'hAC, 0);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("t1_err", {31'b0, err}, 32'd0);
    check("t1_busy_end", {31'b0, busy}, 32'd0);
    check("t1_nwr", nWr - base, 32'd2);

    // Same image, wrong checksum; restarting from DONE reasserts cpu_rst
    base = nWr;
    pulseStart();
    check("t2_cpu_rst_restart", {31'b0, cpu_rst}, 32'd1);
    check("t2_done_clr", {31'b0, done}, 32'd0);
    sendByte(8'h02, 0); sendByte(8'h00, 0);
    sendByte(8'h05, 0); sendByte(8'h00, 0); sendByte(8'h08, 0); sendByte(8'h20, 0);
    sendByte(8'h04, 0); sendByte(8'h00, 0); sendByte(8'h09, 0); sendByte(8'h8C, 0);
    sendByte(8'h00, 0);
    check("t2_err", {31'b0, err}, 32'd1);
    check("t2_done", {31'b0, done}, 32'd0);
    check("t2_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("t2_nwr", nWr - base, 32'd2);
    check("t2_wdata1", wrData[base + 1], 32'h8C090004);

    // Illegal headers: N=0 and N=257
    base = nWr;
    pulseStart();
    check("t3_err_clr", {31'b0, err}, 32'd0);
    sendByte(8'h00, 0); sendByte(8'h00, 0);
    check("t3_n0_err", {31'b0, err}, 32'd1);
    check("t3_n0_ready", {31'b0, in_ready}, 32'd0);
    tick(); tick();
    check("t3_n0_nwr", nWr - base, 32'd0);
    pulseStart();
    sendByte(8'h01, 0); sendByte(8'h01, 0);
    check("t3_n257_err", {31'b0, err}, 32'd1);
    check("t3_n257_busy", {31'b0, busy}, 32'd0);

    // 16-word image, gap-free then with random stalls
    base = nWr;
    pulseStart();
    sendImage(16, 0, 8'h00, -1);
    check("t4_done_nogap", {31'b0, done}, 32'd1);
    base2 = nWr;
    pulseStart();
    sendImage(16, 1, 8'h00, -1);
    check("t4_done_gap", {31'b0, done}, 32'd1);
    check("t4_nwr_nogap", base2 - base, 32'd16);
    check("t4_nwr_gap", nWr - base2, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("t4_addr", {24'b0, wrAddr[base2 + i]}, 32'(i));
      check("t4_data", wrData[base2 + i], wordOf(i));
      check("t4_same_data", wrData[base2 + i], wrData[base + i]);
    end
    check("t4_we_width", weDouble, 32'd0);

    // Reset after the 2nd byte of word 3
    base = nWr;
    pulseStart();
    sendByte(8'h05, 0); sendByte(8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      sendByte(wordOf(i) & 32'hFF, 0);
      sendByte(8'(wordOf(i) >> 8), 0);
      sendByte(8'(wordOf(i) >> 16), 0);
      sendByte(8'(wordOf(i) >> 24), 0);
    end
    sendByte(wordOf(3) & 32'hFF, 0);
    sendByte(8'(wordOf(3) >> 8), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", {31'b0, busy}, 32'd0);
    check("t5_ready", {31'b0, in_ready}, 32'd0);
    check("t5_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("t5_we", {31'b0, mem_we}, 32'd0);
    repeat (4) tick();
    check("t5_nwr", nWr - base, 32'd3);
    base = nWr;
    pulseStart();
    sendImage(4, 0, 8'h00, -1);
    check("t5_reload_done", {31'b0, done}, 32'd1);
    check("t5_reload_nwr", nWr - base, 32'd4);
    check("t5_reload_addr0", {24'b0, wrAddr[base]}, 32'd0);
    check("t5_reload_data3", wrData[base + 3], wordOf(3));

    // start coincident with rst: reset wins
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("t6_rst_wins_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_wins_done", {31'b0, done}, 32'd0);

    // Full-capacity image with a stray start mid-DATA
    base = nWr;
    pulseStart();
    sendImage(256, 0, 8'h00, 10);
    check("t7_done", {31'b0, done}, 32'd1);
    check("t7_cpu_rst", {31'b0, cpu_rst}, 32'd0);
    check("t7_nwr", nWr - base, 32'd256);
    check("t7_addr10", {24'b0, wrAddr[base + 10]}, 32'd10);
    check("t7_last_addr", {24'b0, wrAddr[base + 255]}, 32'hFF);
    check("t7_last_data", wrData[base + 255], wordOf(255));
    check("t7_addr_hold", {24'b0, mem_addr}, 32'hFF);
    pulseStart();
    check("t7_restart_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    check("t7_restart_done", {31'b0, done}, 32'd0);
    check("t7_restart_busy", {31'b0, busy}, 32'd1);
    check("t7_we_width", weDouble, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
